// File: rtl/branch_queue_flush.sv
// branch_queue_flush
//   Circular in-order queue of in-flight branches. Dispatch allocates up to
//   NENQ entries per cycle and receives bq_ids. NRES resolve buses mark
//   entries resolved. Commit peeks and retires up to NDEQ oldest entries.
//   A mispredict (i_flush_v) drops everything younger than i_flush_id and
//   keeps i_flush_id itself. An exception (i_flush_all) drops every entry.
//   Every output is a function of registered state only.
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   i_enq/i_din              allocate lanes (contiguous from 0) + payload
//   o_enq_ready/o_enq_id     lane may allocate / bq_id it receives
//   i_deq                    retire lanes (contiguous from 0)
//   o_dout_valid/o_dout      peek slot tail+k is live / its payload
//   o_dout_res/_taken/_tgt   peek slot resolution state
//   i_res_v/_id/_taken/_tgt  resolve buses; higher bus index wins on a tie
//   i_flush_v/i_flush_id     partial flush of entries younger than id
//   i_flush_all              full flush
//   o_count/o_freespace      live entries / DEPTH - count

// Peek lane: presents entry tail+LANE to commit.
module bq_peek_lane #(
  parameter int DEPTH_BITS = 3,
  parameter int DATA_W     = 32,
  parameter int TGT_W      = 32,
  parameter int LANE       = 0
) (
  input  logic [(1<<DEPTH_BITS)-1:0][DATA_W-1:0] i_data,
  input  logic [(1<<DEPTH_BITS)-1:0]             i_res,
  input  logic [(1<<DEPTH_BITS)-1:0]             i_tkn,
  input  logic [(1<<DEPTH_BITS)-1:0][TGT_W-1:0]  i_tgt,
  input  logic [DEPTH_BITS-1:0]                  i_tail,
  input  logic [DEPTH_BITS:0]                    i_count,
  output logic                                   o_valid,
  output logic [DATA_W-1:0]                      o_dout,
  output logic                                   o_res,
  output logic                                   o_taken,
  output logic [TGT_W-1:0]                       o_tgt
);
  logic [DEPTH_BITS-1:0] w_idx;
  assign w_idx   = i_tail + DEPTH_BITS'(LANE);
  assign o_valid = (DEPTH_BITS+1)'(LANE) < i_count;
  assign o_dout  = i_data[w_idx];
  assign o_res   = i_res[w_idx];
  assign o_taken = i_tkn[w_idx];
  assign o_tgt   = i_tgt[w_idx];
endmodule

module branch_queue_flush #(
  parameter int DEPTH_BITS = 3,
  parameter int NENQ       = 2,
  parameter int NDEQ       = 2,
  parameter int NRES       = 2,
  parameter int DATA_W     = 32,
  parameter int TGT_W      = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NENQ-1:0]                      i_enq,
  input  logic [NENQ-1:0][DATA_W-1:0]          i_din,
  output logic [NENQ-1:0]                      o_enq_ready,
  output logic [NENQ-1:0][DEPTH_BITS-1:0]      o_enq_id,
  input  logic [NDEQ-1:0]                      i_deq,
  output logic [NDEQ-1:0]                      o_dout_valid,
  output logic [NDEQ-1:0][DATA_W-1:0]          o_dout,
  output logic [NDEQ-1:0]                      o_dout_res,
  output logic [NDEQ-1:0]                      o_dout_taken,
  output logic [NDEQ-1:0][TGT_W-1:0]           o_dout_tgt,
  input  logic [NRES-1:0]                      i_res_v,
  input  logic [NRES-1:0][DEPTH_BITS-1:0]      i_res_id,
  input  logic [NRES-1:0]                      i_res_taken,
  input  logic [NRES-1:0][TGT_W-1:0]           i_res_tgt,
  input  logic                                 i_flush_v,
  input  logic [DEPTH_BITS-1:0]                i_flush_id,
  input  logic                                 i_flush_all,
  output logic [DEPTH_BITS:0]                  o_count,
  output logic [DEPTH_BITS:0]                  o_freespace
);
  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam int CW    = DEPTH_BITS + 1;
  localparam int DB    = DEPTH_BITS;

  logic [DB-1:0]                   r_head, r_tail;
  logic [CW-1:0]                   r_count;
  logic [DEPTH-1:0][DATA_W-1:0]    r_data;
  logic [DEPTH-1:0]                r_res, r_tkn;
  logic [DEPTH-1:0][TGT_W-1:0]     r_tgt;

  logic [NENQ-1:0] w_enq_ok;
  logic [NDEQ-1:0] w_deq_ok;
  logic [CW-1:0]   w_n_enq, w_n_deq, w_n_deq_eff, w_fl_keep;
  logic [DB-1:0]   w_fl_off;
  logic            w_flush, w_do_enq;
  logic [NRES-1:0] w_res_we;
  logic [DB-1:0]   w_head_n, w_tail_n;
  logic [CW-1:0]   w_count_n;

  // Offset of an id from the oldest entry; live when it falls inside count.
  function automatic logic [DB-1:0] f_off(input logic [DB-1:0] id, input logic [DB-1:0] tail);
    return id - tail;
  endfunction

  assign o_count     = r_count;
  assign o_freespace = CW'(DEPTH) - r_count;

  for (genvar k = 0; k < NENQ; k++) begin : g_enq
    assign o_enq_ready[k] = CW'(k) < o_freespace;
    assign o_enq_id[k]    = r_head + DB'(k);
  end

  for (genvar k = 0; k < NDEQ; k++) begin : g_peek
    bq_peek_lane #(.DEPTH_BITS(DEPTH_BITS), .DATA_W(DATA_W), .TGT_W(TGT_W), .LANE(k)) u_peek (
      .i_data  (r_data),
      .i_res   (r_res),
      .i_tkn   (r_tkn),
      .i_tgt   (r_tgt),
      .i_tail  (r_tail),
      .i_count (r_count),
      .o_valid (o_dout_valid[k]),
      .o_dout  (o_dout[k]),
      .o_res   (o_dout_res[k]),
      .o_taken (o_dout_taken[k]),
      .o_tgt   (o_dout_tgt[k])
    );
  end

  always_comb begin
    w_enq_ok = i_enq & o_enq_ready;
    w_deq_ok = i_deq & o_dout_valid;
    w_n_enq  = '0;
    w_n_deq  = '0;
    for (int k = 0; k < NENQ; k++) if (w_enq_ok[k]) w_n_enq = w_n_enq + CW'(1);
    for (int k = 0; k < NDEQ; k++) if (w_deq_ok[k]) w_n_deq = w_n_deq + CW'(1);

    w_fl_off  = f_off(i_flush_id, r_tail);
    w_fl_keep = {1'b0, w_fl_off} + CW'(1);
    w_flush   = i_flush_v && !i_flush_all && ({1'b0, w_fl_off} < r_count);
    // Under a partial flush only the survivors can retire.
    w_n_deq_eff = (w_flush && (w_n_deq > w_fl_keep)) ? w_fl_keep : w_n_deq;
    w_do_enq    = !i_flush_all && !w_flush;

    // Slots being enqueued are outside count, so they can never be live here.
    w_res_we = '0;
    for (int r = 0; r < NRES; r++) begin
      w_res_we[r] = i_res_v[r] && !i_flush_all &&
                    ({1'b0, f_off(i_res_id[r], r_tail)} < r_count) &&
                    (!w_flush || (f_off(i_res_id[r], r_tail) <= w_fl_off));
    end

    if (i_flush_all) begin
      w_tail_n  = r_tail + w_n_deq[DB-1:0];
      w_head_n  = w_tail_n;
      w_count_n = '0;
    end else if (w_flush) begin
      w_tail_n  = r_tail + w_n_deq_eff[DB-1:0];
      w_head_n  = i_flush_id + DB'(1);
      w_count_n = w_fl_keep - w_n_deq_eff;
    end else begin
      w_tail_n  = r_tail + w_n_deq[DB-1:0];
      w_head_n  = r_head + w_n_enq[DB-1:0];
      w_count_n = r_count + w_n_enq - w_n_deq;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_res   <= '0;
    end else begin
      r_head  <= w_head_n;
      r_tail  <= w_tail_n;
      r_count <= w_count_n;
      if (w_do_enq)
        for (int k = 0; k < NENQ; k++)
          if (w_enq_ok[k]) r_res[r_head + DB'(k)] <= 1'b0;
      for (int r = 0; r < NRES; r++)
        if (w_res_we[r]) r_res[i_res_id[r]] <= 1'b1;
    end
  end

  // Payload and resolution data need no reset; validity comes from count/r_res.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_do_enq)
        for (int k = 0; k < NENQ; k++)
          if (w_enq_ok[k]) r_data[r_head + DB'(k)] <= i_din[k];
      // Ascending loop: the last (highest) bus hitting an id wins.
      for (int r = 0; r < NRES; r++)
        if (w_res_we[r]) begin
          r_tkn[i_res_id[r]] <= i_res_taken[r];
          r_tgt[i_res_id[r]] <= i_res_tgt[r];
        end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ((i_enq & ~o_enq_ready) == '0)
        else $warning("bq: enqueue on non-ready lane dropped");
      assert ((i_deq & ~o_dout_valid) == '0)
        else $warning("bq: dequeue beyond count ignored");
      assert ((i_enq & (i_enq + NENQ'(1))) == '0)
        else $warning("bq: non-contiguous enqueue lanes");
      assert ((i_deq & (i_deq + NDEQ'(1))) == '0)
        else $warning("bq: non-contiguous dequeue lanes");
      assert (!i_flush_v || i_flush_all || ({1'b0, w_fl_off} < r_count))
        else $warning("bq: flush id not live, ignored");
    end
  end
`endif
endmodule

// File: tb/tb_branch_queue_flush.sv
module tb_branch_queue_flush;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [1:0]       enq, enq_ready, deq, dval, dres, dtkn, res_v, res_taken;
  logic [1:0][31:0] din, dout, dtgt, res_tgt;
  logic [1:0][2:0]  enq_id, res_id;
  logic             flush_v, flush_all;
  logic [2:0]       flush_id;
  logic [3:0]       count, freespace;

  branch_queue_flush dut (
    .clk(clk), .rst(rst),
    .i_enq(enq), .i_din(din), .o_enq_ready(enq_ready), .o_enq_id(enq_id),
    .i_deq(deq), .o_dout_valid(dval), .o_dout(dout), .o_dout_res(dres),
    .o_dout_taken(dtkn), .o_dout_tgt(dtgt),
    .i_res_v(res_v), .i_res_id(res_id), .i_res_taken(res_taken), .i_res_tgt(res_tgt),
    .i_flush_v(flush_v), .i_flush_id(flush_id), .i_flush_all(flush_all),
    .o_count(count), .o_freespace(freespace)
  );

  typedef struct {
    logic rst; logic [1:0] enq; logic [31:0] d0, d1; logic [1:0] deq;
    logic [1:0] rv; logic [2:0] rid0, rid1; logic [1:0] rtk; logic [31:0] rt0, rt1;
    logic fv; logic [2:0] fid; logic fa;
    logic [3:0] e_cnt; logic [2:0] e_id0; logic [1:0] e_val; logic [31:0] e_d0;
    logic [1:0] e_res, e_rdy, e_tk; logic [31:0] e_tg0, e_tg1;
  } vec_t;

  vec_t tbl[$];
  int ncmp = 0, nbad = 0;

  function automatic vec_t vi(logic r, logic [1:0] e, logic [31:0] d0, logic [31:0] d1, logic [1:0] dq);
    vec_t v;
    v = '{default: '0};
    v.rst = r; v.enq = e; v.d0 = d0; v.d1 = d1; v.deq = dq;
    return v;
  endfunction

  task automatic put(input vec_t v, input logic [3:0] cnt, input logic [2:0] id0,
                     input logic [1:0] val, input logic [31:0] d0, input logic [1:0] res,
                     input logic [1:0] rdy, input logic [1:0] tk,
                     input logic [31:0] tg0, input logic [31:0] tg1);
    v.e_cnt = cnt; v.e_id0 = id0; v.e_val = val; v.e_d0 = d0; v.e_res = res;
    v.e_rdy = rdy; v.e_tk = tk; v.e_tg0 = tg0; v.e_tg1 = tg1;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic run(input vec_t v, input string tag);
    @(negedge clk);
    rst = v.rst; enq = v.enq; din[0] = v.d0; din[1] = v.d1; deq = v.deq;
    res_v = v.rv; res_id[0] = v.rid0; res_id[1] = v.rid1; res_taken = v.rtk;
    res_tgt[0] = v.rt0; res_tgt[1] = v.rt1;
    flush_v = v.fv; flush_id = v.fid; flush_all = v.fa;
    @(posedge clk); #1;
    chk({tag, " count"}, 32'(count), 32'(v.e_cnt));
    chk({tag, " freespace"}, 32'(freespace), 32'(4'd8 - v.e_cnt));
    chk({tag, " enq_id0"}, 32'(enq_id[0]), 32'(v.e_id0));
    chk({tag, " enq_ready"}, 32'(enq_ready), 32'(v.e_rdy));
    chk({tag, " dout_valid"}, 32'(dval), 32'(v.e_val));
    if (v.e_val[0]) chk({tag, " dout0"}, dout[0], v.e_d0);
    chk({tag, " dout_res"}, 32'(dres & v.e_val), 32'(v.e_res));
    if (v.e_res[0]) begin
      chk({tag, " taken0"}, 32'(dtkn[0]), 32'(v.e_tk[0]));
      chk({tag, " tgt0"}, dtgt[0], v.e_tg0);
    end
    if (v.e_res[1]) begin
      chk({tag, " taken1"}, 32'(dtkn[1]), 32'(v.e_tk[1]));
      chk({tag, " tgt1"}, dtgt[1], v.e_tg1);
    end
  endtask

  initial begin
    vec_t v;
    rst = 1'b1; enq = '0; din = '0; deq = '0; res_v = '0; res_id = '0;
    res_taken = '0; res_tgt = '0; flush_v = 1'b0; flush_id = '0; flush_all = 1'b0;

    // reset, first allocation, fill to full
    put(vi(1, 2'b00, 0, 0, 2'b00), 0, 0, 2'b00, 0, 2'b00, 2'b11, 0, 0, 0);
    put(vi(0, 2'b11, 'h100, 'h104, 2'b00), 2, 2, 2'b11, 'h100, 2'b00, 2'b11, 0, 0, 0);
    put(vi(0, 2'b11, 'h108, 'h10C, 2'b00), 4, 4, 2'b11, 'h100, 2'b00, 2'b11, 0, 0, 0);
    put(vi(0, 2'b11, 'h110, 'h114, 2'b00), 6, 6, 2'b11, 'h100, 2'b00, 2'b11, 0, 0, 0);
    put(vi(0, 2'b11, 'h118, 'h11C, 2'b00), 8, 0, 2'b11, 'h100, 2'b00, 2'b00, 0, 0, 0);
    // full: deq 2 + enq 2 -> enq dropped, tail=2
    put(vi(0, 2'b11, 'hDEAD, 'hBEEF, 2'b11), 6, 0, 2'b11, 'h108, 2'b00, 2'b11, 0, 0, 0);
    // resolve: ids 0..3 live
    put(vi(1, 2'b00, 0, 0, 2'b00), 0, 0, 2'b00, 0, 2'b00, 2'b11, 0, 0, 0);
    put(vi(0, 2'b11, 'hA0, 'hA1, 2'b00), 2, 2, 2'b11, 'hA0, 2'b00, 2'b11, 0, 0, 0);
    put(vi(0, 2'b11, 'hA2, 'hA3, 2'b00), 4, 4, 2'b11, 'hA0, 2'b00, 2'b11, 0, 0, 0);
    v = vi(0, 2'b00, 0, 0, 2'b00); v.rv = 2'b11; v.rid0 = 1; v.rid1 = 1; v.rtk = 2'b01;
    v.rt0 = 'h200; v.rt1 = 'h300;
    put(v, 4, 4, 2'b11, 'hA0, 2'b10, 2'b11, 2'b00, 0, 'h300);
    v = vi(0, 2'b00, 0, 0, 2'b00); v.rv = 2'b11; v.rid0 = 0; v.rid1 = 5; v.rtk = 2'b11;
    v.rt0 = 'h400; v.rt1 = 'h555;
    put(v, 4, 4, 2'b11, 'hA0, 2'b11, 2'b11, 2'b01, 'h400, 'h300);
    put(vi(0, 2'b00, 0, 0, 2'b01), 3, 4, 2'b11, 'hA1, 2'b01, 2'b11, 2'b00, 'h300, 0);
    // build wrapped ids 6,7,0,1,2
    put(vi(0, 2'b00, 0, 0, 2'b11), 1, 4, 2'b01, 'hA3, 2'b00, 2'b11, 0, 0, 0);
    put(vi(0, 2'b11, 'hB4, 'hB5, 2'b01), 2, 6, 2'b11, 'hB4, 2'b00, 2'b11, 0, 0, 0);
    put(vi(0, 2'b11, 'hB6, 'hB7, 2'b11), 2, 0, 2'b11, 'hB6, 2'b00, 2'b11, 0, 0, 0);
    put(vi(0, 2'b11, 'hB0, 'hB1, 2'b00), 4, 2, 2'b11, 'hB6, 2'b00, 2'b11, 0, 0, 0);
    put(vi(0, 2'b01, 'hB2, 0, 2'b00), 5, 3, 2'b11, 'hB6, 2'b00, 2'b11, 0, 0, 0);
    // partial flush id 7 + deq lane0 + enq (ignored) + resolve on the survivor
    v = vi(0, 2'b11, 'hEE0, 'hEE1, 2'b01); v.fv = 1; v.fid = 7;
    v.rv = 2'b01; v.rid0 = 7; v.rtk = 2'b01; v.rt0 = 'h777;
    put(v, 1, 0, 2'b01, 'hB7, 2'b01, 2'b11, 2'b01, 'h777, 0);
    put(vi(0, 2'b01, 'hC0, 0, 2'b00), 2, 1, 2'b11, 'hB7, 2'b01, 2'b11, 2'b01, 'h777, 0);
    // full flush at count 5 with enq 2 and deq 1
    put(vi(0, 2'b11, 'hC1, 'hC2, 2'b00), 4, 3, 2'b11, 'hB7, 2'b01, 2'b11, 2'b01, 'h777, 0);
    put(vi(0, 2'b01, 'hC3, 0, 2'b00), 5, 4, 2'b11, 'hB7, 2'b01, 2'b11, 2'b01, 'h777, 0);
    v = vi(0, 2'b11, 'hEE2, 'hEE3, 2'b01); v.fa = 1;
    put(v, 0, 0, 2'b00, 0, 2'b00, 2'b11, 0, 0, 0);
    put(vi(0, 2'b01, 'hD0, 0, 2'b00), 1, 1, 2'b01, 'hD0, 2'b00, 2'b11, 0, 0, 0);
    // reset mid-stream with count 4 and pending resolves
    put(vi(0, 2'b11, 'hD1, 'hD2, 2'b00), 3, 3, 2'b11, 'hD0, 2'b00, 2'b11, 0, 0, 0);
    put(vi(0, 2'b01, 'hD3, 0, 2'b00), 4, 4, 2'b11, 'hD0, 2'b00, 2'b11, 0, 0, 0);
    v = vi(1, 2'b11, 'hEE4, 'hEE5, 2'b00); v.rv = 2'b11; v.rid0 = 0; v.rid1 = 1; v.rtk = 2'b11;
    put(v, 0, 0, 2'b00, 0, 2'b00, 2'b11, 0, 0, 0);
    put(vi(0, 2'b01, 'hE0, 0, 2'b00), 1, 1, 2'b01, 'hE0, 2'b00, 2'b11, 0, 0, 0);

    foreach (tbl[i]) run(tbl[i], $sformatf("v%0d", i));

    // Partial flush at the oldest entry with deq 2: only one survivor may retire.
    v = vi(0, 2'b11, 'hF1, 'hF2, 2'b00);
    v.e_cnt = 3; v.e_id0 = 3; v.e_val = 2'b11; v.e_d0 = 'hE0; v.e_rdy = 2'b11;
    run(v, "h_fill");
    chk("h_fill enq_id1", 32'(enq_id[1]), 32'd4);
    v = vi(0, 2'b00, 0, 0, 2'b11); v.fv = 1; v.fid = 0;
    v.e_cnt = 0; v.e_id0 = 1; v.e_val = 2'b00; v.e_rdy = 2'b11;
    run(v, "h_flush_tail");
    chk("h_flush_tail enq_id1", 32'(enq_id[1]), 32'd2);
    v = vi(0, 2'b01, 'hF9, 0, 2'b00);
    v.e_cnt = 1; v.e_id0 = 2; v.e_val = 2'b01; v.e_d0 = 'hF9; v.e_rdy = 2'b11;
    run(v, "h_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end
endmodule
